nib_pack: RTL
=============

// Module: nib_pack
// PURPOSE
//  Downstream stage of the four-lane nibble mux. Consumes the muxed 4-bit nibble
//  stream under a valid/ready handshake and packs four consecutive nibbles into a
//  16-bit word, LSN first. Packed words are buffered in a DEPTH-entry FIFO and
//  presented to the consumer under a second valid/ready handshake.
//  A flush input emits a partially filled word, zero-padded.
// PARAMETERS
//  DEPTH   4   FIFO depth in words; power of two, >= 2
//  CNT_W   3   width of fifo_count; must equal log2(DEPTH)+1
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  reset       in   1      synchronous, active-high reset
//  nib_in      in   4      nibble from the upstream mux
//  nib_valid   in   1      nib_in is valid this cycle
//  nib_ready   out  1      stage can accept a nibble this cycle
//  flush       in   1      close the current partial word (honoured only when nib_ready=1)
//  word_out    out  16     FIFO head word; nibble k is at bits [4k+3:4k]
//  word_nibs   out  3      number of real nibbles in word_out, 1..4 (0 when empty)
//  word_valid  out  1      FIFO non-empty
//  word_ready  in   1      consumer takes word_out this cycle
//  fifo_count  out  CNT_W  words currently held in the FIFO, 0..DEPTH
// BEHAVIOUR
//  Reset: takes effect on the clock edge where reset=1.
//   - Clears acc_cnt, acc_data, the FIFO pointers and fifo_count.
//   - While reset=1: nib_ready=0, word_valid=0, word_out=0, word_nibs=0, fifo_count=0.
//   - Reset asserted mid-word discards the partial word and all buffered words.
//  Ready/valid signals:
//   - nib_ready = !reset && (fifo_count != DEPTH). Decoded from registers only;
//     a pop in the same cycle does not raise it.
//   - Accept = nib_valid & nib_ready. Pop = word_valid & word_ready.
//  Accumulator FSM on acc_cnt: S0 (empty), S1, S2, S3 (nibbles held).
//   - Accept in Sn, n<3, no flush: acc_data[4n+:4] <= nib_in; go to S(n+1).
//   - Accept in S3: push {nib_in, acc_data[11:0]} with nibs=4; clear acc_data; go to S0.
//   - flush with nib_ready=1:
//       - With an accept in Sn: write the nibble, push with nibs=n+1, go to S0.
//       - Without an accept, in Sn, n>0: push acc_data with nibs=n, go to S0.
//       - Without an accept, in S0: no push, no effect.
//   - flush with nib_ready=0: ignored. Upstream holds flush until it is honoured.
//   - Unused upper nibbles of a pushed word are 0.
//  FIFO:
//   - Storage is DEPTH x 19 bits (16 data + 3 nibs). Pointers wrap modulo DEPTH.
//   - Latency: a word pushed at edge t has word_valid=1 after edge t (1 cycle).
//   - word_out and word_nibs show the head entry when word_valid=1, and are
//     forced to 0 when the FIFO is empty.
//   - Push and pop in the same cycle: fifo_count unchanged, pointers both advance.
//   - Push and pop are never simultaneous when full; nib_ready=0 blocks the push.
//   - Pop when empty cannot occur (word_valid=0).
//   - Reaching fifo_count=DEPTH drops nib_ready on the following cycle.
//  nib_in and nib_valid are ignored while nib_ready=0. No data is lost or duplicated.
// TESTING
//  T1:
//   - Stimulus: after reset, with word_ready=1, accept nibbles 1,2,3,4 on consecutive cycles.
//   - Response: word_out=0x4321, word_nibs=4, word_valid=1 for one cycle after the 4th accept.
//  T2:
//   - Stimulus: accept 1,5 then pulse flush with nib_valid=0.
//   - Response: word_out=0x0051, word_nibs=2. Then send 7,4 with flush on the 4 -> 0x0047, nibs=2.
//  T3:
//   - Stimulus: word_ready=0; stream 16 nibbles 0..F.
//   - Response: fifo_count reaches 4 and nib_ready=0.
//     Pop one -> nib_ready=1 next cycle; heads seen 0x3210, 0x7654, 0xBA98, 0xFEDC.
//  T4:
//   - Stimulus: with fifo_count=2, complete a word while word_ready=1.
//   - Response: fifo_count stays 2 and pop order is preserved.
//  T5:
//   - Stimulus: accept 1,2, assert reset one cycle, then accept 8,5,3,4.
//   - Response: only 0x4358 nibs=4 appears; outputs are 0 during reset.
//  T6:
//   - Stimulus: flush in S0 with nib_valid=0; also flush while FIFO full.
//   - Response: no push and fifo_count unchanged in both cases.

Source files
------------

// File: rtl/nib_pack.sv
// nib_pack: packs a nibble stream LSN-first into 16-bit words and buffers them in a DEPTH-entry FIFO
module nib_pack #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       nib_in,
  input  logic             nib_valid,
  output logic             nib_ready,
  input  logic             flush,
  output logic [15:0]      word_out,
  output logic [2:0]       word_nibs,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;
  state_t           r_state, w_next;
  logic [11:0]      r_acc_data;
  logic [18:0]      r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_accept, w_flush, w_pop, w_push;
  logic [15:0]      w_nib_sh, w_acc_ext, w_push_data;
  logic [2:0]       w_push_nibs;
  logic [18:0]      w_head;
  assign nib_ready  = !reset && (r_count != CNT_W'(DEPTH));
  assign word_valid = !reset && (r_count != '0);
  assign w_accept   = nib_valid && nib_ready;
  assign w_flush    = flush && nib_ready;
  assign w_pop      = word_valid && word_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign word_out   = word_valid ? w_head[15:0] : '0;
  assign word_nibs  = word_valid ? w_head[18:16] : '0;
  assign fifo_count = reset ? '0 : r_count;
  assign w_acc_ext  = {4'h0, r_acc_data};
  assign w_nib_sh   = 16'(nib_in) << {r_state, 2'b00};
  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_push_data = w_acc_ext | w_nib_sh;
    w_push_nibs = {1'b0, r_state} + 3'd1;
    if (w_accept) begin
      w_push = w_flush || (r_state == S3);
      w_next = w_push ? S0 : state_t'(r_state + 2'd1);
    end else if (w_flush && r_state != S0) begin
      w_push      = 1'b1;
      w_push_data = w_acc_ext;
      w_push_nibs = {1'b0, r_state};
      w_next      = S0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S0;
      r_acc_data <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_acc_data <= (w_next == S0) ? '0 : w_accept ? (r_acc_data | w_nib_sh[11:0]) : r_acc_data;
      r_wr_ptr   <= w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
      r_rd_ptr   <= w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= {w_push_nibs, w_push_data};
  end
endmodule
